// File: rtl/norflash_linebuf.sv
// norflash_linebuf: single-line read buffer between the Wishbone bus and the NOR flash controller.
// Ports: sys_clk, sys_rst_n (sync, active-low); s_* upstream Wishbone slave;
//        m_* downstream Wishbone master to the flash controller; flush invalidates the line.
module norflash_linebuf #(
    parameter int adr_width = 24,
    parameter int line_log2 = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [31:0] s_adr_i,
    input  logic [31:0] s_dat_i,
    output logic [31:0] s_dat_o,
    input  logic [3:0]  s_sel_i,
    input  logic        s_stb_i,
    input  logic        s_cyc_i,
    input  logic        s_we_i,
    output logic        s_ack_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    output logic [3:0]  m_sel_o,
    output logic        m_stb_o,
    output logic        m_cyc_o,
    output logic        m_we_o,
    input  logic        m_ack_i,
    input  logic        flush
);
    localparam int WORDS = 1 << line_log2;
    localparam int TAG_W = adr_width - line_log2 - 2;
    localparam int HI_W  = 32 - adr_width;
    localparam logic [line_log2-1:0] IDX_LAST = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HIT,
        ST_FILL,
        ST_WRITE,
        ST_ACK
    } state_t;

    state_t               state;
    logic [31:0]          line_q [WORDS];
    logic [TAG_W-1:0]     tag_q;
    logic                 valid_q;
    logic                 flush_pend_q;
    logic [line_log2-1:0] idx_q;
    logic [line_log2-1:0] word_q;

    logic                 req;
    logic [TAG_W-1:0]     req_tag;
    logic [line_log2-1:0] req_word;
    logic                 hit;
    logic [line_log2-1:0] idx_nxt;
    logic [31:0]          fill_word;
    logic                 unused_adr;

    assign req      = s_cyc_i & s_stb_i;
    assign req_tag  = s_adr_i[adr_width-1:line_log2+2];
    assign req_word = s_adr_i[line_log2+1:2];
    assign hit      = valid_q && (tag_q == req_tag);
    // Wraps to zero after the last word, never carries into the tag.
    assign idx_nxt  = idx_q + line_log2'(1);
    // The word arriving now may be the requested one; earlier ones are stored.
    assign fill_word = (word_q == idx_q) ? m_dat_i : line_q[word_q];
    assign unused_adr = ^{s_adr_i[31:adr_width], s_adr_i[1:0]};

    always_ff @(posedge sys_clk) begin
        if (sys_rst_n && state == ST_FILL && m_ack_i) begin
            line_q[idx_q] <= m_dat_i;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state        <= ST_IDLE;
            s_ack_o      <= 1'b0;
            s_dat_o      <= '0;
            m_cyc_o      <= 1'b0;
            m_stb_o      <= 1'b0;
            m_we_o       <= 1'b0;
            m_sel_o      <= '0;
            m_adr_o      <= '0;
            m_dat_o      <= '0;
            valid_q      <= 1'b0;
            flush_pend_q <= 1'b0;
            tag_q        <= '0;
            idx_q        <= '0;
            word_q       <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (flush) valid_q <= 1'b0;
                    if (req) begin
                        if (s_we_i) begin
                            state   <= ST_WRITE;
                            valid_q <= 1'b0;
                            m_cyc_o <= 1'b1;
                            m_stb_o <= 1'b1;
                            m_we_o  <= 1'b1;
                            m_adr_o <= {{HI_W{1'b0}}, s_adr_i[adr_width-1:2], 2'b00};
                            m_dat_o <= s_dat_i;
                            m_sel_o <= s_sel_i;
                        end else if (hit) begin
                            state   <= ST_HIT;
                            s_ack_o <= 1'b1;
                            s_dat_o <= line_q[req_word];
                        end else begin
                            state        <= ST_FILL;
                            valid_q      <= 1'b0;
                            tag_q        <= req_tag;
                            idx_q        <= '0;
                            word_q       <= req_word;
                            flush_pend_q <= flush;
                            m_cyc_o      <= 1'b1;
                            m_stb_o      <= 1'b1;
                            m_we_o       <= 1'b0;
                            m_sel_o      <= 4'b1111;
                            m_adr_o      <= {{HI_W{1'b0}}, req_tag,
                                             {line_log2{1'b0}}, 2'b00};
                        end
                    end
                end
                ST_HIT: begin
                    if (flush) valid_q <= 1'b0;
                    s_ack_o <= 1'b0;
                    state   <= ST_IDLE;
                end
                ST_FILL: begin
                    if (flush) flush_pend_q <= 1'b1;
                    if (m_ack_i) begin
                        idx_q <= idx_nxt;
                        if (idx_q == IDX_LAST) begin
                            m_cyc_o <= 1'b0;
                            m_stb_o <= 1'b0;
                            valid_q <= !(flush_pend_q || flush);
                            s_dat_o <= fill_word;
                            // An abandoned cycle still completes, but is not acked.
                            s_ack_o <= req;
                            state   <= ST_ACK;
                        end else begin
                            m_adr_o <= {{HI_W{1'b0}}, tag_q, idx_nxt, 2'b00};
                        end
                    end
                end
                ST_WRITE: begin
                    if (m_ack_i) begin
                        m_cyc_o <= 1'b0;
                        m_stb_o <= 1'b0;
                        m_we_o  <= 1'b0;
                        s_ack_o <= req;
                        state   <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (flush) valid_q <= 1'b0;
                    s_ack_o <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_norflash_linebuf.sv
// tb_norflash_linebuf: scoreboard bench with a flash slave model and a line-level cache model.
// Ports: none (top-level bench driving norflash_linebuf).
module tb_norflash_linebuf;
    typedef struct packed {
        logic        wr;
        logic [31:0] dat;
    } up_t;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } ds_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [31:0] s_adr_i = '0;
    logic [31:0] s_dat_i = '0;
    logic [31:0] s_dat_o;
    logic [3:0]  s_sel_i = '0;
    logic        s_stb_i = 1'b0;
    logic        s_cyc_i = 1'b0;
    logic        s_we_i = 1'b0;
    logic        s_ack_o;
    logic [31:0] m_adr_o;
    logic [31:0] m_dat_o;
    logic [31:0] m_dat_i;
    logic [3:0]  m_sel_o;
    logic        m_stb_o;
    logic        m_cyc_o;
    logic        m_we_o;
    logic        m_ack_i;
    logic        flush;
    logic        flush_idle = 1'b0;
    logic        flush_ack = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int ack_count = 0;
    int last_mack_cyc = 0;
    int acks_seen = 0;
    int flush_at = -1;

    up_t up_q[$];
    ds_t ds_q[$];

    // Line-level model: which line is held and whether it is usable.
    logic        mdl_valid = 1'b0;
    logic [19:0] mdl_tag = '0;

    assign flush = flush_idle | flush_ack;

    norflash_linebuf dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .s_adr_i   (s_adr_i),
        .s_dat_i   (s_dat_i),
        .s_dat_o   (s_dat_o),
        .s_sel_i   (s_sel_i),
        .s_stb_i   (s_stb_i),
        .s_cyc_i   (s_cyc_i),
        .s_we_i    (s_we_i),
        .s_ack_o   (s_ack_o),
        .m_adr_o   (m_adr_o),
        .m_dat_o   (m_dat_o),
        .m_dat_i   (m_dat_i),
        .m_sel_o   (m_sel_o),
        .m_stb_o   (m_stb_o),
        .m_cyc_o   (m_cyc_o),
        .m_we_o    (m_we_o),
        .m_ack_i   (m_ack_i),
        .flush     (flush)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc_n++;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    // Upstream monitor: every ack must match the oldest outstanding request.
    always @(negedge sys_clk) begin
        up_t e;
        if (sys_rst_n && s_ack_o) begin
            acks_seen++;
            if (up_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL up_unexpected_ack actual ack=1 required ack=0");
            end else begin
                e = up_q.pop_front();
                if (!e.wr) chk("up_rdata", s_dat_o, e.dat);
            end
        end
    end

    // Flash slave: random wait states, checks each accepted transfer.
    initial begin
        ds_t e;
        bit busy;
        int wt;
        busy = 1'b0;
        wt = 0;
        m_ack_i = 1'b0;
        m_dat_i = '0;
        forever begin
            @(posedge sys_clk);
            #1;
            m_ack_i = 1'b0;
            flush_ack = 1'b0;
            if (!(sys_rst_n && m_cyc_o && m_stb_o)) begin
                busy = 1'b0;
            end else begin
                if (!busy) begin
                    busy = 1'b1;
                    wt = $urandom_range(0, 3);
                end
                if (wt == 0) begin
                    busy = 1'b0;
                    m_ack_i = 1'b1;
                    m_dat_i = m_we_o ? 32'h0 : mem_f(m_adr_o);
                    ack_count++;
                    last_mack_cyc = cyc_n;
                    if (ack_count == flush_at) flush_ack = 1'b1;
                    if (ds_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL ds_unexpected actual adr=%h required none",
                                 m_adr_o);
                    end else begin
                        e = ds_q.pop_front();
                        chk("ds_adr", m_adr_o, e.adr);
                        chk("ds_we", {31'b0, m_we_o}, {31'b0, e.we});
                        chk("ds_sel", {28'b0, m_sel_o}, {28'b0, e.sel});
                        if (e.we) chk("ds_wdat", m_dat_o, e.dat);
                    end
                end else begin
                    wt--;
                end
            end
        end
    end

    task automatic wait_ack(output int n);
        n = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge sys_clk);
            n++;
            if (s_ack_o) break;
        end
        if (!s_ack_o) n = -1;
    endtask

    task automatic push_line(input logic [31:0] a);
        ds_t d;
        for (int i = 0; i < 4; i++) begin
            d.we  = 1'b0;
            d.adr = {8'h0, a[23:4], 4'h0} + 32'(i * 4);
            d.dat = '0;
            d.sel = 4'hf;
            ds_q.push_back(d);
        end
    endtask

    task automatic wb_read(input logic [31:0] a, input bit fmid);
        bit  hit;
        int  a0;
        int  n;
        up_t u;
        hit = mdl_valid && (mdl_tag == a[23:4]);
        u.wr = 1'b0;
        u.dat = mem_f({8'h0, a[23:2], 2'b00});
        up_q.push_back(u);
        if (!hit) push_line(a);
        a0 = ack_count;
        @(posedge sys_clk);
        #1;
        s_adr_i = a;
        s_we_i = 1'b0;
        s_sel_i = 4'hf;
        s_cyc_i = 1'b1;
        s_stb_i = 1'b1;
        @(posedge sys_clk);
        wait_ack(n);
        chk("rd_ack_seen", {31'b0, s_ack_o}, 32'd1);
        if (hit) begin
            chk("hit_latency", n, 32'd1);
            chk("hit_no_ds", ack_count - a0, 32'd0);
        end else begin
            chk("miss_ds_words", ack_count - a0, 32'd4);
            chk("miss_ack_after_mack", cyc_n - last_mack_cyc, 32'd1);
        end
        @(posedge sys_clk);
        #1;
        s_cyc_i = 1'b0;
        s_stb_i = 1'b0;
        if (!hit) begin
            mdl_tag = a[23:4];
            mdl_valid = !fmid;
        end
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] sel);
        ds_t e;
        up_t u;
        int  n;
        e.we = 1'b1;
        e.adr = {8'h0, a[23:2], 2'b00};
        e.dat = d;
        e.sel = sel;
        ds_q.push_back(e);
        u.wr = 1'b1;
        u.dat = '0;
        up_q.push_back(u);
        @(posedge sys_clk);
        #1;
        s_adr_i = a;
        s_dat_i = d;
        s_we_i = 1'b1;
        s_sel_i = sel;
        s_cyc_i = 1'b1;
        s_stb_i = 1'b1;
        @(posedge sys_clk);
        wait_ack(n);
        chk("wr_ack_seen", {31'b0, s_ack_o}, 32'd1);
        chk("wr_ack_after_mack", cyc_n - last_mack_cyc, 32'd1);
        @(posedge sys_clk);
        #1;
        s_cyc_i = 1'b0;
        s_stb_i = 1'b0;
        s_we_i = 1'b0;
        mdl_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        @(posedge sys_clk);
        #1;
        flush_idle = 1'b1;
        @(posedge sys_clk);
        #1;
        flush_idle = 1'b0;
        mdl_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
    end

    initial begin
        int a0;
        int s0;
        int r;
        logic [31:0] a;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_s_ack", {31'b0, s_ack_o}, 32'd0);
        chk("rst_s_dat", s_dat_o, 32'd0);
        chk("rst_m_cyc", {31'b0, m_cyc_o}, 32'd0);
        chk("rst_m_stb", {31'b0, m_stb_o}, 32'd0);
        chk("rst_m_we", {31'b0, m_we_o}, 32'd0);
        chk("rst_m_sel", {28'b0, m_sel_o}, 32'd0);
        chk("rst_m_adr", m_adr_o, 32'd0);
        chk("rst_m_dat", m_dat_o, 32'd0);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;

        wb_read(32'h0000_0104, 1'b0);
        wb_read(32'h0000_0100, 1'b0);
        wb_read(32'h0000_010C, 1'b0);
        wb_read(32'h0000_0110, 1'b0);
        wb_read(32'h0000_0118, 1'b0);

        wb_write(32'h0000_0AAA, 32'h00AA_AA00, 4'b0011);
        wb_read(32'h0000_0114, 1'b0);

        flush_at = ack_count + 2;
        wb_read(32'h0000_0208, 1'b1);
        flush_at = -1;
        wb_read(32'h0000_0208, 1'b0);

        a0 = ack_count;
        push_line(32'h0000_0300);
        @(posedge sys_clk);
        #1;
        s_adr_i = 32'h0000_0304;
        s_we_i = 1'b0;
        s_sel_i = 4'hf;
        s_cyc_i = 1'b1;
        s_stb_i = 1'b1;
        for (int k = 0; k < 400 && ack_count == a0; k++) @(negedge sys_clk);
        chk("rst_first_mack", ack_count - a0, 32'd1);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b0;
        s_cyc_i = 1'b0;
        s_stb_i = 1'b0;
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("midrst_m_cyc", {31'b0, m_cyc_o}, 32'd0);
        chk("midrst_s_ack", {31'b0, s_ack_o}, 32'd0);
        chk("midrst_s_dat", s_dat_o, 32'd0);
        ds_q.delete();
        mdl_valid = 1'b0;
        wb_read(32'h0000_0304, 1'b0);

        a0 = ack_count;
        push_line(32'h0000_0400);
        @(posedge sys_clk);
        #1;
        s_adr_i = 32'h0000_0408;
        s_we_i = 1'b0;
        s_sel_i = 4'hf;
        s_cyc_i = 1'b1;
        s_stb_i = 1'b1;
        for (int k = 0; k < 400 && ack_count == a0; k++) @(negedge sys_clk);
        @(posedge sys_clk);
        #1;
        s_cyc_i = 1'b0;
        s_stb_i = 1'b0;
        s0 = acks_seen;
        for (int k = 0; k < 400 && ack_count < a0 + 4; k++) @(negedge sys_clk);
        repeat (3) @(negedge sys_clk);
        chk("abandon_ds_words", ack_count - a0, 32'd4);
        chk("abandon_no_ack", acks_seen - s0, 32'd0);
        mdl_valid = 1'b1;
        mdl_tag = 20'h00040;
        wb_read(32'h0000_040C, 1'b0);

        pulse_flush();
        wb_read(32'h0000_0404, 1'b0);

        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 9);
            a = 32'h100 + ($urandom_range(0, 31) << 2);
            if ($urandom_range(0, 3) == 0) a[31:24] = 8'($urandom);
            if (r == 0) begin
                wb_write(a, $urandom, ($urandom_range(0, 1) != 0) ? 4'b0011 : 4'b1100);
            end else if (r == 1) begin
                pulse_flush();
            end else begin
                wb_read(a, 1'b0);
            end
        end

        repeat (5) @(negedge sys_clk);
        chk("up_q_drained", up_q.size(), 32'd0);
        chk("ds_q_drained", ds_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/norflash_linebuf.md
# norflash_linebuf

Read line buffer between the system Wishbone bus and the 16-bit NOR flash controller. Flash reads cost roughly 13 cycles per halfword, so the block fetches an aligned line of 32-bit words on a miss and serves later reads in that line from registers. Writes (flash command sequences) pass through unchanged and invalidate the line. The upstream side is a Wishbone slave (`s_*`); the downstream side is a Wishbone master (`m_*`) wired directly to the flash controller's slave port.

## Interface
- `adr_width`, default 24: byte-address width forwarded downstream.
- `line_log2`, default 2: log2 of words per line (4 words = 16 bytes); legal values are 1 to 4.
- `sys_clk`, in, 1: sole clock; all logic uses the rising edge.
- `sys_rst_n`, in, 1: reset, synchronous and active-low.
- `s_adr_i`, in, 32: upstream byte address.
- `s_dat_i`, in, 32: upstream write data.
- `s_dat_o`, out, 32: upstream read data.
- `s_sel_i`, in, 4: byte selects.
- `s_stb_i`, `s_cyc_i`, `s_we_i`, in, 1 each: Wishbone strobe, cycle and write enable.
- `s_ack_o`, out, 1: upstream acknowledge.
- `m_adr_o`, out, 32: downstream address; bits 31:adr_width and 1:0 are zero.
- `m_dat_o`, out, 32: downstream write data.
- `m_dat_i`, in, 32: downstream read data.
- `m_sel_o`, out, 4: downstream byte selects.
- `m_stb_o`, `m_cyc_o`, `m_we_o`, out, 1 each: downstream strobe, cycle and write enable.
- `m_ack_i`, in, 1: downstream acknowledge.
- `flush`, in, 1: single-cycle pulse that invalidates the line.

## Operation
- Storage: `2^line_log2` 32-bit data words, one tag (`s_adr_i[adr_width-1:line_log2+2]`) and one `valid` bit.
- A request is sampled in IDLE when `s_cyc_i & s_stb_i`.
- **IDLE**
  - Write → WRITE.
  - Read with `valid` set and tag match (hit) → HIT: latch the word selected by `s_adr_i[line_log2+1:2]` into `s_dat_o`.
  - Read miss → FILL: clear `valid`, load the new tag, set fill index to 0.
- **HIT**: `s_ack_o`=1 for one cycle → IDLE.
- **FILL**
  - Drive `m_cyc_o`/`m_stb_o`=1, `m_we_o`=0, `m_sel_o`=4'b1111, `m_adr_o`={tag, index, 2'b00}.
  - On each `m_ack_i`: store `m_dat_i` at the index, then increment the index.
  - After the last word: set `valid` unless a flush is pending, latch the requested word into `s_dat_o` → ACK.
  - Words are fetched in ascending order from index 0. There is no critical-word-first.
- **WRITE**
  - Drive `m_cyc_o`/`m_stb_o`/`m_we_o`=1, with `m_adr_o`, `m_sel_o` and `m_dat_o` registered from upstream.
  - Clear `valid` on entry.
  - On `m_ack_i` → ACK.
  - `s_sel_i` is forwarded as-is. Only 4'b0011 and 4'b1100 are meaningful downstream; other patterns are the master's responsibility.
- **ACK**: `s_ack_o`=1 for one cycle, only if `s_cyc_i & s_stb_i` are still high → IDLE.
- All `m_*` outputs and `s_ack_o` are registered; `s_ack_o` is never combinational from `s_stb_i`.
- Byte and halfword reads return the full 32-bit word; the upstream master picks its lanes.

## Timing
- Reset values: `s_ack_o`=0, `s_dat_o`=0, `m_cyc_o`=`m_stb_o`=`m_we_o`=0, `m_sel_o`=0, `m_adr_o`=0, `m_dat_o`=0, `valid`=0, state=IDLE, flush-pending=0.
- Hit latency: stb sampled at edge N, `s_ack_o` high during cycle N+1, back in IDLE at N+2. A new request can therefore be sampled every 2 cycles.
- Miss latency: 1 cycle + the sum of the downstream transfer times + 1 ACK cycle.
- `m_stb_o` deasserts in the cycle after the final `m_ack_i`. Between words of a fill, `m_stb_o` stays high and `m_adr_o` updates on the same edge as the ack.
- Boundary behaviour:
  - `flush` in IDLE, HIT or ACK: `valid` cleared at the next edge.
  - `flush` during FILL: flush-pending is set. The fill completes and returns data, but `valid` stays 0.
  - `s_cyc_i` dropped during FILL or WRITE: the downstream transfer runs to completion, because the flash controller cannot abort. No upstream ack is issued. The line is still validated after a completed fill.
  - `flush` and a write in the same cycle: `valid`=0; no conflict.
  - Last word index (all ones) terminates the fill. The index wraps to 0 and does not overflow into the tag.
  - `sys_rst_n` low mid-operation: return to IDLE with all outputs at reset values. The flash controller shares the reset, so no downstream recovery is required.

## Test plan
- **Cold miss then hits**
  - Stimulus: read 0x000104, then 0x000100, 0x00010C.
  - Required: first read issues 4 downstream reads at 0x100, 0x104, 0x108, 0x10C and returns word 1. The next two reads ack at N+1 with no downstream activity.
- **Tag change**
  - Stimulus: after a fill of 0x100, read 0x000110.
  - Required: new 4-word fill at 0x110–0x11C; the old data is not returned.
- **Write passthrough**
  - Stimulus: write 0x00AAAA00 to 0x000AAA, sel=4'b0011.
  - Required: downstream sees identical adr/dat/sel with `m_we_o`=1; upstream ack 1 cycle after `m_ack_i`. A subsequent read of the cached line misses.
- **Flush mid-fill**
  - Stimulus: pulse `flush` on the second `m_ack_i` of a fill.
  - Required: correct data is returned; an immediate re-read of the same address refetches all 4 words.
- **Reset mid-fill**
  - Stimulus: drive `sys_rst_n`=0 for 1 cycle after the first `m_ack_i`.
  - Required: the next cycle has `m_cyc_o`=0 and `s_ack_o`=0; a following read of the same line performs a full fill.
- **Abandoned cycle**
  - Stimulus: drop `s_cyc_i` during a fill.
  - Required: all 4 downstream reads still complete, no `s_ack_o`, and a later read of that line hits.
